// File: rtl/max_pool_engine_if.sv
// Temp-RAM port bundle shared by the max-pool engine (master) and the feature-map RAM (slave).
interface max_pool_engine_if;
    logic [15:0] ram_addr_r_MP;
    logic        ram_en_r_MP;
    logic [7:0]  ram_data_r;
    logic [15:0] ram_addr_w_MP;
    logic [7:0]  ram_data_w_MP;
    logic        ram_en_MP;
    logic        ram_wea_MP;

    modport master (
        output ram_addr_r_MP, ram_en_r_MP, ram_addr_w_MP, ram_data_w_MP, ram_en_MP, ram_wea_MP,
        input  ram_data_r
    );

    modport slave (
        input  ram_addr_r_MP, ram_en_r_MP, ram_addr_w_MP, ram_data_w_MP, ram_en_MP, ram_wea_MP,
        output ram_data_r
    );
endinterface

// File: rtl/max_pool_engine.sv
// 2x2 stride-2 unsigned max pooling, in place on a channel-major temp RAM.
// One window per 6 cycles: 4 reads, a drain cycle for the last read, one write.
module max_pool_engine #(
    parameter int MP1_H = 48,
    parameter int MP1_W = 48,
    parameter int MP1_C = 8,
    parameter int MP2_H = 20,
    parameter int MP2_W = 20,
    parameter int MP2_C = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_MP1,
    input  logic              start_MP2,
    output logic              end_MP1,
    output logic              end_MP2,
    max_pool_engine_if.master ram
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        LAST    = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4,
        WAITLOW = 3'd5
    } state_t;

    localparam logic [15:0] MP1_W_C  = 16'(MP1_W);
    localparam logic [15:0] MP1_QMAX = 16'(MP1_W / 2 - 1);
    localparam logic [15:0] MP1_RMAX = 16'(MP1_H / 2 - 1);
    localparam logic [15:0] MP1_CMAX = 16'(MP1_C - 1);
    localparam logic [15:0] MP2_W_C  = 16'(MP2_W);
    localparam logic [15:0] MP2_QMAX = 16'(MP2_W / 2 - 1);
    localparam logic [15:0] MP2_RMAX = 16'(MP2_H / 2 - 1);
    localparam logic [15:0] MP2_CMAX = 16'(MP2_C - 1);

    function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] m;
        if (a >= b) m = a;
        else        m = b;
        return m;
    endfunction

    state_t      state_r, state_nxt_s;
    logic        layer_r, layer_nxt_s;          // 0 = MP1, 1 = MP2
    logic [1:0]  k_r, k_nxt_s;
    logic [15:0] q_r, q_nxt_s, row_r, row_nxt_s, ch_r, ch_nxt_s;
    logic [15:0] base_r, base_nxt_s;            // read address of the window's top-left pixel
    logic [15:0] waddr_r, waddr_nxt_s;
    logic [7:0]  max_r, max_nxt_s;
    logic        start_sel_s, last_win_s;
    logic [15:0] w_s, qmax_s, rmax_s, cmax_s, w_nxt_s, rd_off_s;
    logic        rd_en_nxt_s, wr_en_nxt_s, end1_nxt_s, end2_nxt_s;
    logic [15:0] rd_addr_nxt_s, wr_addr_nxt_s;
    logic [7:0]  wr_data_nxt_s;

    assign start_sel_s = layer_r ? start_MP2 : start_MP1;
    assign last_win_s  = (q_r == qmax_s) && (row_r == rmax_s) && (ch_r == cmax_s);

    // Geometry of the latched layer
    always_comb begin
        if (layer_r) begin
            w_s = MP2_W_C; qmax_s = MP2_QMAX; rmax_s = MP2_RMAX; cmax_s = MP2_CMAX;
        end else begin
            w_s = MP1_W_C; qmax_s = MP1_QMAX; rmax_s = MP1_RMAX; cmax_s = MP1_CMAX;
        end
    end

    // Next-state, counter and running-max logic
    always_comb begin
        state_nxt_s = state_r;
        layer_nxt_s = layer_r;
        k_nxt_s     = k_r;
        q_nxt_s     = q_r;
        row_nxt_s   = row_r;
        ch_nxt_s    = ch_r;
        base_nxt_s  = base_r;
        waddr_nxt_s = waddr_r;
        max_nxt_s   = max_r;
        case (state_r)
            IDLE: begin
                if (start_MP1 || start_MP2) begin
                    state_nxt_s = READ;
                    layer_nxt_s = !start_MP1;
                    k_nxt_s     = 2'd0;
                    q_nxt_s     = 16'd0;
                    row_nxt_s   = 16'd0;
                    ch_nxt_s    = 16'd0;
                    base_nxt_s  = 16'd0;
                    waddr_nxt_s = 16'd0;
                    max_nxt_s   = 8'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                // data for read k-1 arrives during cycle k
                if (k_r == 2'd1)      max_nxt_s = ram.ram_data_r;
                else if (k_r != 2'd0) max_nxt_s = max_u8(max_r, ram.ram_data_r);
                else                  max_nxt_s = max_r;
                if (!start_sel_s)       state_nxt_s = IDLE;
                else if (k_r == 2'd3)   state_nxt_s = LAST;
                else begin
                    state_nxt_s = READ;
                    k_nxt_s     = k_r + 2'd1;
                end
            end
            LAST: begin
                max_nxt_s = max_u8(max_r, ram.ram_data_r);
                if (!start_sel_s) state_nxt_s = IDLE;
                else              state_nxt_s = WRITE;
            end
            WRITE: begin
                if (!start_sel_s)    state_nxt_s = IDLE;
                else if (last_win_s) state_nxt_s = DONE;
                else begin
                    state_nxt_s = READ;
                    k_nxt_s     = 2'd0;
                    waddr_nxt_s = waddr_r + 16'd1;
                    // stepping past a row end (or channel end) skips the odd input row
                    if (q_r == qmax_s) begin
                        q_nxt_s    = 16'd0;
                        base_nxt_s = base_r + w_s + 16'd2;
                        if (row_r == rmax_s) begin
                            row_nxt_s = 16'd0;
                            ch_nxt_s  = ch_r + 16'd1;
                        end else begin
                            row_nxt_s = row_r + 16'd1;
                        end
                    end else begin
                        q_nxt_s    = q_r + 16'd1;
                        base_nxt_s = base_r + 16'd2;
                    end
                end
            end
            DONE:    state_nxt_s = WAITLOW;
            WAITLOW: begin
                if (!start_MP1 && !start_MP2) state_nxt_s = IDLE;
                else                          state_nxt_s = WAITLOW;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        if (layer_nxt_s) w_nxt_s = MP2_W_C;
        else             w_nxt_s = MP1_W_C;
        case (k_nxt_s)
            2'd0:    rd_off_s = 16'd0;
            2'd1:    rd_off_s = 16'd1;
            2'd2:    rd_off_s = w_nxt_s;
            2'd3:    rd_off_s = w_nxt_s + 16'd1;
            default: rd_off_s = 16'd0;
        endcase
        if (state_nxt_s == READ) begin
            rd_en_nxt_s   = 1'b1;
            rd_addr_nxt_s = base_nxt_s + rd_off_s;
        end else begin
            rd_en_nxt_s   = 1'b0;
            rd_addr_nxt_s = 16'd0;
        end
        if (state_nxt_s == WRITE) begin
            wr_en_nxt_s   = 1'b1;
            wr_addr_nxt_s = waddr_nxt_s;
            wr_data_nxt_s = max_nxt_s;
        end else begin
            wr_en_nxt_s   = 1'b0;
            wr_addr_nxt_s = 16'd0;
            wr_data_nxt_s = 8'd0;
        end
        if (state_nxt_s == DONE) begin
            end1_nxt_s = !layer_nxt_s;
            end2_nxt_s = layer_nxt_s;
        end else begin
            end1_nxt_s = 1'b0;
            end2_nxt_s = 1'b0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= IDLE;
            layer_r           <= 1'b0;
            k_r               <= 2'd0;
            q_r               <= 16'd0;
            row_r             <= 16'd0;
            ch_r              <= 16'd0;
            base_r            <= 16'd0;
            waddr_r           <= 16'd0;
            max_r             <= 8'd0;
            ram.ram_en_r_MP   <= 1'b0;
            ram.ram_addr_r_MP <= 16'd0;
            ram.ram_en_MP     <= 1'b0;
            ram.ram_wea_MP    <= 1'b0;
            ram.ram_addr_w_MP <= 16'd0;
            ram.ram_data_w_MP <= 8'd0;
            end_MP1           <= 1'b0;
            end_MP2           <= 1'b0;
        end else begin
            state_r           <= state_nxt_s;
            layer_r           <= layer_nxt_s;
            k_r               <= k_nxt_s;
            q_r               <= q_nxt_s;
            row_r             <= row_nxt_s;
            ch_r              <= ch_nxt_s;
            base_r            <= base_nxt_s;
            waddr_r           <= waddr_nxt_s;
            max_r             <= max_nxt_s;
            ram.ram_en_r_MP   <= rd_en_nxt_s;
            ram.ram_addr_r_MP <= rd_addr_nxt_s;
            ram.ram_en_MP     <= wr_en_nxt_s;
            ram.ram_wea_MP    <= wr_en_nxt_s;
            ram.ram_addr_w_MP <= wr_addr_nxt_s;
            ram.ram_data_w_MP <= wr_data_nxt_s;
            end_MP1           <= end1_nxt_s;
            end_MP2           <= end2_nxt_s;
        end
    end
endmodule

// File: tb/tb_max_pool_engine.sv
// Scoreboard bench for max_pool_engine: a RAM model, expected writes/end pulses queued by the
// stimulus, and a negedge monitor that pops and compares whatever the engine presents.
module tb_max_pool_engine;
    localparam int MP1_H = 48, MP1_W = 48, MP1_C = 8;
    localparam int MP2_H = 20, MP2_W = 20, MP2_C = 16;
    localparam int MP1_N = MP1_C * (MP1_H / 2) * (MP1_W / 2);
    localparam int MP2_N = MP2_C * (MP2_H / 2) * (MP2_W / 2);

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int mp2;  int cyc;  } end_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_MP1 = 1'b0;
    logic start_MP2 = 1'b0;
    logic end_MP1, end_MP2;

    int tests = 0, fails = 0, cyc = 0;
    int wr_cnt = 0, first_waddr = -1, last_waddr = -1;
    int preload_sel = 0;
    wr_t  exp_q[$];
    end_t end_q[$];
    wr_t  wr_e;
    end_t end_e;
    logic [7:0] mem [0:32767];

    max_pool_engine_if bus ();

    max_pool_engine #(
        .MP1_H(MP1_H), .MP1_W(MP1_W), .MP1_C(MP1_C),
        .MP2_H(MP2_H), .MP2_W(MP2_W), .MP2_C(MP2_C)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_MP1(start_MP1), .start_MP2(start_MP2),
        .end_MP1(end_MP1), .end_MP2(end_MP2), .ram(bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Preload patterns: 1 = (i mod 251) with three hand-built windows, 2 = (7i+3) mod 256
    function automatic logic [7:0] pattern(input int sel, input int i);
        if (sel == 1) begin
            case (i)
                2:           return 8'd3;
                3:           return 8'd200;
                50:          return 8'd7;
                51:          return 8'd199;
                4, 5, 52:    return 8'd0;
                53:          return 8'd255;
                6, 7, 54, 55: return 8'd17;
                default:     return 8'(i % 251);
            endcase
        end
        return 8'((i * 7 + 3) % 256);
    endfunction

    // RAM model: one-cycle read latency, write on the clock edge
    always @(posedge clk) begin
        if (preload_sel != 0) begin
            for (int i = 0; i < 32768; i++) mem[i] <= pattern(preload_sel, i);
        end else begin
            if (bus.ram_en_r_MP) bus.ram_data_r <= mem[bus.ram_addr_r_MP[14:0]];
            if (bus.ram_en_MP && bus.ram_wea_MP) mem[bus.ram_addr_w_MP[14:0]] <= bus.ram_data_w_MP;
        end
    end

    task automatic check(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic preload(input int sel);
        @(posedge clk); #1;
        preload_sel = sel;
        @(posedge clk); #1;
        preload_sel = 0;
    endtask

    // Expected writes straight from the pooling definition on the current RAM contents
    task automatic build_expected(input int mp2);
        int h, w, ch, a, m;
        h  = mp2 ? MP2_H : MP1_H;
        w  = mp2 ? MP2_W : MP1_W;
        ch = mp2 ? MP2_C : MP1_C;
        for (int c = 0; c < ch; c++)
            for (int r = 0; r < h / 2; r++)
                for (int q = 0; q < w / 2; q++) begin
                    a = c * h * w + 2 * r * w + 2 * q;
                    m = int'(mem[a]);
                    if (int'(mem[a + 1]) > m)     m = int'(mem[a + 1]);
                    if (int'(mem[a + w]) > m)     m = int'(mem[a + w]);
                    if (int'(mem[a + w + 1]) > m) m = int'(mem[a + w + 1]);
                    exp_q.push_back('{addr: c * (h / 2) * (w / 2) + r * (w / 2) + q, data: m});
                end
    endtask

    task automatic wait_end(input int budget, input string nm);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (end_MP1 || end_MP2) break;
        end
        tests++;
        if (i >= budget) begin
            fails++;
            $display("FAIL %s: no end pulse within %0d cycles", nm, budget);
        end
    endtask

    task automatic count_activity(input int ncyc, output int n);
        n = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (bus.ram_en_r_MP || bus.ram_en_MP) n++;
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_rd_en"},   int'(bus.ram_en_r_MP), 0);
        check({nm, "_rd_addr"}, int'(bus.ram_addr_r_MP), 0);
        check({nm, "_wr_en"},   int'(bus.ram_en_MP), 0);
        check({nm, "_wea"},     int'(bus.ram_wea_MP), 0);
        check({nm, "_wr_addr"}, int'(bus.ram_addr_w_MP), 0);
        check({nm, "_wr_data"}, int'(bus.ram_data_w_MP), 0);
        check({nm, "_ends"},    int'({end_MP2, end_MP1}), 0);
    endtask

    // Monitor: compare every presented write and end pulse against the queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ram_en_MP) begin
                if (wr_cnt == 0) first_waddr = int'(bus.ram_addr_w_MP);
                wr_cnt++;
                last_waddr = int'(bus.ram_addr_w_MP);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0d data %0d, expected no write (cycle %0d)",
                             bus.ram_addr_w_MP, bus.ram_data_w_MP, cyc);
                end else begin
                    wr_e = exp_q.pop_front();
                    check("write_addr", int'(bus.ram_addr_w_MP), wr_e.addr);
                    check("write_data", int'(bus.ram_data_w_MP), wr_e.data);
                    check("write_wea",  int'(bus.ram_wea_MP), 1);
                end
            end else begin
                check("idle_write_port", int'({bus.ram_wea_MP, bus.ram_addr_w_MP, bus.ram_data_w_MP}), 0);
            end
            if (!bus.ram_en_r_MP) check("idle_read_addr", int'(bus.ram_addr_r_MP), 0);
            if (end_MP1 || end_MP2) begin
                if (end_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_end: end_MP1 %0b end_MP2 %0b, expected none (cycle %0d)",
                             end_MP1, end_MP2, cyc);
                end else begin
                    end_e = end_q.pop_front();
                    check("end_layer", int'({end_MP2, end_MP1}), end_e.mp2 != 0 ? 2 : 1);
                    check("end_cycle", cyc, end_e.cyc);
                end
            end
        end
    end

    initial begin
        int n, t0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Both starts together: MP1 wins, full run, then start held past DONE
        preload(1);
        build_expected(0);
        wr_cnt = 0; first_waddr = -1;
        @(posedge clk); #1;
        start_MP1 = 1'b1; start_MP2 = 1'b1; t0 = cyc;
        end_q.push_back('{mp2: 0, cyc: t0 + 6 * MP1_N + 1});
        wait_end(6 * MP1_N + 50, "mp1_end_timeout");
        count_activity(40, n);
        check("held_start_no_rerun", n, 0);
        start_MP1 = 1'b0; start_MP2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mp1_write_count", wr_cnt, MP1_N);
        check("mp1_first_addr", first_waddr, 0);
        check("mp1_last_addr", last_waddr, 4607);
        check("mp1_pending_writes", exp_q.size(), 0);
        check("mp1_out_000", int'(mem[0]), 49);
        check("win_3_200_7_199", int'(mem[1]), 200);
        check("win_0_0_0_255", int'(mem[2]), 255);
        check("win_all_17", int'(mem[3]), 17);

        // MP2 aborted in window 10 READ
        preload(2);
        build_expected(1);
        wr_cnt = 0; first_waddr = -1;
        @(posedge clk); #1;
        start_MP2 = 1'b1;
        n = 0;
        for (int i = 0; i < 200 && n < 10; i++) begin
            @(negedge clk);
            if (bus.ram_en_MP) n++;
        end
        check("abort_reached_window10", n, 10);
        @(posedge clk); #1;
        start_MP2 = 1'b0;
        check("abort_writes_consumed", exp_q.size(), MP2_N - 10);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check("abort_idle_next_cycle", int'(bus.ram_en_r_MP), 0);
        count_activity(30, n);
        check("abort_no_activity", n, 0);

        // MP2 restarted from window 0 and run to completion
        build_expected(1);
        wr_cnt = 0; first_waddr = -1;
        @(posedge clk); #1;
        start_MP2 = 1'b1; t0 = cyc;
        end_q.push_back('{mp2: 1, cyc: t0 + 6 * MP2_N + 1});
        wait_end(6 * MP2_N + 50, "mp2_end_timeout");
        start_MP2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mp2_write_count", wr_cnt, MP2_N);
        check("mp2_restart_first_addr", first_waddr, 0);
        check("mp2_last_addr", last_waddr, 1599);
        check("mp2_pending_writes", exp_q.size(), 0);

        // Reset asserted during a WRITE cycle
        build_expected(1);
        wr_cnt = 0; first_waddr = -1;
        @(posedge clk); #1;
        start_MP2 = 1'b1;
        n = 0;
        for (int i = 0; i < 50 && n == 0; i++) begin
            @(negedge clk);
            if (bus.ram_en_MP) n = 1;
        end
        check("reset_reached_write", n, 1);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid_write");
        exp_q.delete();
        start_MP2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        count_activity(20, n);
        check("post_reset_stays_idle", n, 0);
        check("pending_end_pulses", end_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
